fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage and IF/ID pipeline register of the MIPS datapath. Holds the PC and issues word fetches to instruction memory over a req/ack handshake that tolerates multi-cycle latency. Captures returned instructions into the IF/ID register, whose opcode and funct fields feed the control unit directly. Supports decode-stage stall (one-entry skid buffer) and EX-stage branch redirect with flush.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `imem_req` output 1: fetch request.
- `imem_addr` output 32: word address of the request; bits [1:0] are always 0.
- `imem_ack` input 1: response strobe; meaningful only while `imem_req` = 1.
- `imem_rdata` input 32: instruction; valid in the `imem_ack` cycle.
- `stall` input 1: decode cannot accept; hold IF/ID.
- `branch_taken` input 1: redirect pulse from EX.
- `branch_target` input 32: redirect address; bits [1:0] are ignored (forced 0).
- `if_id_valid` output 1: IF/ID holds a live instruction.
- `if_id_instr` output 32: IF/ID instruction.
- `if_id_pc4` output 32: PC+4 of the IF/ID instruction.
- `opcode` output 6: `if_id_instr[31:26]`, to control unit.
- `funct` output 6: `if_id_instr[5:0]`, to control unit.

## Operation

- States: IDLE, FETCH, BUFFERED, DRAIN.
- Reset: state IDLE, `pc` = RESET_PC, `imem_req` = 0, `if_id_valid` = 0, `if_id_instr` = 0 (NOP), `if_id_pc4` = 0, buffer empty.
- IDLE: on the first edge after reset release, go to FETCH.
- FETCH: `imem_req` = 1, `imem_addr` = `pc`. Once asserted, req and addr stay stable until ack; the only exception is address retargeting via DRAIN.
  - ack, no stall, no branch: load IF/ID with `imem_rdata` and `pc`+4, set `if_id_valid` = 1, set `pc` = `pc`+4, and stay in FETCH. The next request is issued back-to-back in the following cycle.
  - ack with stall: IF/ID holds. Write the instruction and PC+4 into the skid buffer, set `pc` = `pc`+4, and go to BUFFERED.
  - Stall without ack: keep the request outstanding; IF/ID holds.
- BUFFERED: `imem_req` = 0. When `stall` = 0, move the buffer into IF/ID (valid = 1) and go to FETCH.
- Branch (`branch_taken` = 1), in any non-IDLE state; it takes priority over stall and ack:
  - Clear IF/ID (`if_id_valid` = 0, `if_id_instr` = 0) and empty the buffer.
  - Set `pc` = {`branch_target`[31:2], 2'b00}.
  - In FETCH without ack: go to DRAIN.
  - In FETCH with ack in the same cycle: discard the data and stay in FETCH at the target.
  - In BUFFERED: go to FETCH.
- DRAIN: keep `imem_req` = 1 with the old address. On ack, discard the data and go to FETCH at the new `pc`. A further branch while in DRAIN just overwrites `pc`.
- Invalid IF/ID presents instr 0 (opcode 0, funct 0 = sll $0). Control then writes $zero, which is harmless.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- `rst` asserted mid-transaction returns all state to reset values immediately. Any in-flight ack is then ignored, because `imem_req` = 0.

## Timing

- Fetch latency: IF/ID updates on the edge where `imem_ack` is sampled high.
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle.
- Branch: IF/ID is invalid in the cycle after the pulse. The first request at the target is issued in the cycle after the pulse (FETCH), or in the cycle after the drained ack (DRAIN).
- Buffer release: IF/ID updates on the first edge with `stall` = 0; `imem_req` rises in the following cycle.
- `opcode` and `funct` are combinational slices of the IF/ID register.

## Configuration

- `FETCH_PERF_CNT_EN` defined: adds output ports `perf_fetch_cnt[31:0]` and `perf_flush_cnt[31:0]`. Both reset to 0 and wrap at 2^32.
  - `perf_fetch_cnt` increments on each accepted (non-discarded) ack.
  - `perf_flush_cnt` increments on each `branch_taken` cycle.
- Macro undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan

- Reset release with RESET_PC = 0 and a zero-wait memory returning addr+0x100 -> `imem_addr` sequence 0, 4, 8. IF/ID instr 0x100, 0x104, 0x108 on consecutive cycles; pc4 = 4, 8, 12.
- 3-cycle-latency memory -> `imem_req` and `imem_addr` stable for 3 cycles. IF/ID updates once per ack; `if_id_valid` never drops after the first fetch.
- `stall` = 1 for 4 cycles spanning an ack at addr 8:
  - IF/ID holds the addr-4 instruction.
  - BUFFERED state, `imem_req` = 0.
  - After release, IF/ID gets the addr-8 instruction, then a request issues at 12.
- `branch_taken` with target 0x43 while a request at 0x10 is outstanding -> IF/ID flushed (instr 0). The ack for 0x10 is discarded, and the next request is at 0x40.
- `branch_taken` and `stall` in the same cycle with the buffer full -> flush wins: valid = 0, buffer empty, next request at the target. Also cover PC wrap from 0xFFFF_FFFC to 0.
- Assert `rst` during DRAIN -> all outputs return to reset values. A following ack is ignored, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage
//   MIPS instruction fetch stage with the IF/ID pipeline register.
//   Holds the PC and issues word fetches over a req/ack handshake that
//   tolerates multi-cycle memory latency. A one-entry skid buffer absorbs a
//   returning instruction while decode stalls. A branch redirect from EX
//   flushes IF/ID and retargets the PC.
//
// Ports
//   clk, rst           : clock, asynchronous active-high reset
//   imem_req/addr      : fetch request and word address (addr[1:0] = 0)
//   imem_ack/rdata     : response strobe and instruction data
//   stall              : decode cannot accept; IF/ID holds
//   branch_taken/target: redirect pulse and target address from EX
//   if_id_valid/instr/pc4 : IF/ID pipeline register
//   opcode, funct      : instruction fields to the control unit
//
// Configuration
//   FETCH_PERF_CNT_EN  : when defined, adds perf_fetch_cnt (accepted fetches)
//                        and perf_flush_cnt (branch redirect cycles).

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic [5:0]  opcode,
    output logic [5:0]  funct
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        BUFFERED,
        DRAIN
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc4;
    logic [31:0] pc_next;
    logic [31:0] target;

    assign pc_next = pc + 32'd4;
    assign target  = {branch_target[31:2], 2'b00};

    assign opcode  = if_id_instr[31:26];
    assign funct   = if_id_instr[5:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc4   <= '0;
            buf_instr   <= '0;
            buf_pc4     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end

                FETCH: begin
                    if (branch_taken) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= '0;
                        pc          <= target;
                        // Without an ack the old request must complete with
                        // its original address, so the retarget waits in DRAIN.
                        if (imem_ack) begin
                            imem_addr <= target;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        pc <= pc_next;
                        if (stall) begin
                            buf_instr <= imem_rdata;
                            buf_pc4   <= pc_next;
                            imem_req  <= 1'b0;
                            imem_addr <= pc_next;
                            state     <= BUFFERED;
                        end else begin
                            if_id_valid <= 1'b1;
                            if_id_instr <= imem_rdata;
                            if_id_pc4   <= pc_next;
                            imem_addr   <= pc_next;
                        end
                    end
                end

                BUFFERED: begin
                    if (branch_taken) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= '0;
                        pc          <= target;
                        imem_req    <= 1'b1;
                        imem_addr   <= target;
                        state       <= FETCH;
                    end else if (!stall) begin
                        if_id_valid <= 1'b1;
                        if_id_instr <= buf_instr;
                        if_id_pc4   <= buf_pc4;
                        imem_req    <= 1'b1;
                        imem_addr   <= pc;
                        state       <= FETCH;
                    end
                end

                DRAIN: begin
                    if (branch_taken) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= '0;
                        pc          <= target;
                    end
                    // The drained data is dropped; the next request goes to
                    // the most recent redirect target.
                    if (imem_ack) begin
                        imem_addr <= branch_taken ? target : pc;
                        state     <= FETCH;
                    end
                end

                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (state == FETCH && imem_ack && !branch_taken) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (branch_taken) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A latency-programmable memory model
//   answers requests; a transaction-level reference model tracks the PC, the
//   outstanding request, the skid entry and IF/ID, and all DUT outputs are
//   compared against it every cycle on the falling edge.

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [5:0]  opcode;
    logic [5:0]  funct;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .if_id_valid  (if_id_valid),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .opcode       (opcode),
        .funct        (funct)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- memory model ----------------
    int mem_lat   = 0;   // fixed latency in cycles, -1 = random 0..3
    bit mem_busy  = 0;
    int mem_cnt   = 0;
    int mem_wait  = 0;
    bit force_ack = 0;

    task automatic drive_mem();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (force_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
        end else if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1;
                mem_cnt  = 0;
                mem_wait = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
            end
            if (mem_cnt == mem_wait) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr + 32'h100;
                mem_busy   = 0;
            end else begin
                mem_cnt++;
            end
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    entry_t      skid[$];
    bit          m_started;
    bit          m_req;
    bit          m_stale;   // outstanding request belongs to a flushed path
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;

    task automatic model_reset();
        skid.delete();
        m_started = 0;
        m_req     = 0;
        m_stale   = 0;
        m_addr    = 32'h0;
        m_pc      = 32'h0;
        m_valid   = 0;
        m_instr   = 32'h0;
        m_pc4     = 32'h0;
    endtask

    task automatic model_step();
        entry_t e;
        bit     got;
        got = imem_ack && m_req;
        if (!m_started) begin
            m_started = 1;
            m_req     = 1;
            m_addr    = m_pc;
        end else if (branch_taken) begin
            m_valid = 0;
            m_instr = 32'h0;
            skid.delete();
            m_pc = branch_target & ~32'h3;
            if (!m_req || got) begin
                m_req   = 1;
                m_addr  = m_pc;
                m_stale = 0;
            end else begin
                m_stale = 1;
            end
        end else if (got && m_stale) begin
            m_stale = 0;
            m_addr  = m_pc;
        end else if (got) begin
            e.instr = imem_rdata;
            e.pc4   = m_addr + 32'd4;
            m_pc    = e.pc4;
            if (stall) begin
                skid.push_back(e);
                m_req = 0;
            end else begin
                m_valid = 1;
                m_instr = e.instr;
                m_pc4   = e.pc4;
                m_addr  = m_pc;
            end
        end else if (skid.size() != 0 && !stall) begin
            e       = skid.pop_front();
            m_valid = 1;
            m_instr = e.instr;
            m_pc4   = e.pc4;
            m_req   = 1;
            m_addr  = m_pc;
        end
    endtask

    task automatic compare_all();
        check("req", 32'(imem_req), 32'(m_req));
        if (m_req) check("addr", imem_addr, m_addr);
        check("valid", 32'(if_id_valid), 32'(m_valid));
        check("instr", if_id_instr, m_instr);
        if (m_valid) check("pc4", if_id_pc4, m_pc4);
        check("opcode", 32'(opcode), 32'(m_instr[31:26]));
        check("funct", 32'(funct), 32'(m_instr[5:0]));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit st, input bit br, input logic [31:0] tgt);
        compare_all();
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        drive_mem();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle, held for one cycle.
    task automatic async_reset();
        #2;
        rst          = 1'b1;
        imem_ack     = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        #1;
        model_reset();
        mem_busy = 0;
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        check("rst_req", 32'(imem_req), 32'h0);
        check("rst_valid", 32'(if_id_valid), 32'h0);
        rst = 1'b0;

        // Zero-wait memory: back-to-back fetches from 0.
        mem_lat = 0;
        step(0, 0, 0);
        check("t1_addr0", imem_addr, 32'h0);
        step(0, 0, 0);
        check("t1_instr0", if_id_instr, 32'h100);
        check("t1_pc4_0", if_id_pc4, 32'h4);
        check("t1_addr1", imem_addr, 32'h4);
        step(0, 0, 0);
        check("t1_instr1", if_id_instr, 32'h104);
        check("t1_pc4_1", if_id_pc4, 32'h8);
        step(0, 0, 0);
        check("t1_instr2", if_id_instr, 32'h108);
        check("t1_pc4_2", if_id_pc4, 32'hC);

        // Multi-cycle memory: request held across wait cycles.
        mem_lat = 2;
        repeat (12) step(0, 0, 0);

        // Stall spanning an ack, then release.
        mem_lat = 1;
        repeat (4) step(1, 0, 0);
        repeat (6) step(0, 0, 0);

        // Branch while a request is outstanding (target 0x43 -> 0x40).
        mem_lat = 3;
        step(0, 0, 0);
        step(0, 1, 32'h43);
        check("t4_flush", if_id_instr, 32'h0);
        repeat (8) step(0, 0, 0);

        // Branch + stall with the buffer full; target just below the wrap.
        mem_lat = 0;
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 32'hFFFF_FFFC);
        check("t5_valid", 32'(if_id_valid), 32'h0);
        repeat (4) step(0, 0, 0);

        // Reset asserted while draining; a stray ack after release is ignored.
        mem_lat = 3;
        step(0, 0, 0);
        step(0, 1, 32'h200);
        step(0, 0, 0);
        async_reset();
        force_ack = 1;
        step(0, 0, 0);
        force_ack = 0;
        mem_lat = 0;
        check("t6_addr", imem_addr, 32'h0);
        repeat (4) step(0, 0, 0);

        // Randomized traffic.
        mem_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                logic [31:0] tgt;
                tgt = $urandom;
                if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, tgt);
            end
        end
        compare_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
